// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, alu_op encodings and R-type funct values.
package alu_pkg;

    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned REG_W   = 5;

    typedef enum logic [CTRL_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_ILL = 4'b0011,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_XOR = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [OP_W-1:0] {
        OP_MEM    = 2'b00,
        OP_BRANCH = 2'b01,
        OP_RTYPE  = 2'b10,
        OP_ORI    = 2'b11
    } alu_op_e;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FUNCT_W-1:0] FN_XOR = 6'b100110;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational alu_op/funct decode into the 4-bit ALU control code.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]    alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTRL_W-1:0]  ctrl_c,
    output logic               illegal_c
);

    always_comb begin
        ctrl_c    = ALU_ADD;
        illegal_c = 1'b0;
        case (alu_op_e'(alu_op))
            OP_MEM:    ctrl_c = ALU_ADD;
            OP_BRANCH: ctrl_c = ALU_SUB;
            OP_ORI:    ctrl_c = ALU_OR;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  ctrl_c = ALU_ADD;
                    FN_SUB:  ctrl_c = ALU_SUB;
                    FN_AND:  ctrl_c = ALU_AND;
                    FN_OR:   ctrl_c = ALU_OR;
                    FN_SLT:  ctrl_c = ALU_SLT;
                    FN_XOR:  ctrl_c = ALU_XOR;
                    default: begin
                        ctrl_c    = ALU_ILL;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            default: ctrl_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decode, operand select, two-entry skid buffer with flush
// and a saturating illegal-funct counter.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               alu_src,
    input  logic [DW-1:0]      rs_data,
    input  logic [DW-1:0]      rt_data,
    input  logic [IMM_W-1:0]   imm16,
    input  logic [REG_W-1:0]   rd_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [DW-1:0]      in1,
    output logic [DW-1:0]      in2,
    output logic [REG_W-1:0]   rd_out,
    output logic               illegal,
    output logic [CW-1:0]      illegal_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CTRL_W-1:0] dec_ctrl_c;
    logic              dec_ill_c;
    logic [DW-1:0]     op2_c;
    logic              accept_c;
    logic              m_load_c;
    logic              s_take_c;
    logic              m_valid_n_c;
    logic              s_valid_n_c;

    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DW-1:0]     s_in1;
    logic [DW-1:0]     s_in2;
    logic [REG_W-1:0]  s_rd;
    logic              s_ill;

    alu_ctrl_decode u_dec (
        .alu_op    (alu_op),
        .funct     (funct),
        .ctrl_c    (dec_ctrl_c),
        .illegal_c (dec_ill_c)
    );

    // ori zero-extends its immediate; every other immediate user sign-extends
    always_comb begin
        op2_c = rt_data;
        if (alu_src) begin
            if (alu_op == OP_ORI) op2_c = DW'(imm16);
            else                  op2_c = {{(DW-IMM_W){imm16[IMM_W-1]}}, imm16};
        end
    end

    // S only takes the input when M is stalled, or to keep ordering behind a draining S
    always_comb begin
        accept_c    = in_valid & in_ready & ~flush;
        m_load_c    = ~out_valid | out_ready;
        s_take_c    = accept_c & (~m_load_c | s_valid);
        m_valid_n_c = out_valid;
        s_valid_n_c = s_valid;
        if (flush) begin
            m_valid_n_c = 1'b0;
            s_valid_n_c = 1'b0;
        end else begin
            if (m_load_c) m_valid_n_c = s_valid | accept_c;
            s_valid_n_c = (s_valid & ~m_load_c) | s_take_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            s_valid   <= 1'b0;
        end else begin
            out_valid <= m_valid_n_c;
            s_valid   <= s_valid_n_c;
            in_ready  <= ~s_valid_n_c;
        end
    end

    // main register payload; S always has priority to preserve order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl    <= '0;
            in1     <= '0;
            in2     <= '0;
            rd_out  <= '0;
            illegal <= 1'b0;
        end else if (!flush && m_load_c) begin
            if (s_valid) begin
                ctrl    <= s_ctrl;
                in1     <= s_in1;
                in2     <= s_in2;
                rd_out  <= s_rd;
                illegal <= s_ill;
            end else if (accept_c) begin
                ctrl    <= dec_ctrl_c;
                in1     <= rs_data;
                in2     <= op2_c;
                rd_out  <= rd_in;
                illegal <= dec_ill_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ctrl <= '0;
            s_in1  <= '0;
            s_in2  <= '0;
            s_rd   <= '0;
            s_ill  <= 1'b0;
        end else if (s_take_c) begin
            s_ctrl <= dec_ctrl_c;
            s_in1  <= rs_data;
            s_in2  <= op2_c;
            s_rd   <= rd_in;
            s_ill  <= dec_ill_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (accept_c && dec_ill_c && (illegal_cnt != CNT_MAX)) begin
            illegal_cnt <= illegal_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: depth-2 FIFO reference model compared every cycle,
// plus directed literal checks.
module tb_alu_issue_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [5:0]      funct;
    logic            alu_src;
    logic [DW-1:0]   rs_data;
    logic [DW-1:0]   rt_data;
    logic [15:0]     imm16;
    logic [4:0]      rd_in;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      ctrl;
    logic [DW-1:0]   in1;
    logic [DW-1:0]   in2;
    logic [4:0]      rd_out;
    logic            illegal;
    logic [CW-1:0]   illegal_cnt;

    alu_issue_stage #(.DW(DW), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_src     (alu_src),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .imm16       (imm16),
        .rd_in       (rd_in),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ctrl        (ctrl),
        .in1         (in1),
        .in2         (in2),
        .rd_out      (rd_out),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]    ctrl;
        logic [DW-1:0] in1;
        logic [DW-1:0] in2;
        logic [4:0]    rd;
        logic          ill;
    } ent_t;

    ent_t        mq[$];
    int unsigned mcnt;
    bit          m_acc;
    bit          m_pop;
    ent_t        m_e;

    function automatic ent_t expect_entry(logic [1:0] op, logic [5:0] fn, logic src,
                                          logic [DW-1:0] rs, logic [DW-1:0] rt,
                                          logic [15:0] imm, logic [4:0] rd);
        ent_t e;
        e.ill = 1'b0;
        case (op)
            2'b00: e.ctrl = 4'b0010;
            2'b01: e.ctrl = 4'b0110;
            2'b11: e.ctrl = 4'b0001;
            default: begin
                if      (fn == 6'b100000) e.ctrl = 4'b0010;
                else if (fn == 6'b100010) e.ctrl = 4'b0110;
                else if (fn == 6'b100100) e.ctrl = 4'b0000;
                else if (fn == 6'b100101) e.ctrl = 4'b0001;
                else if (fn == 6'b101010) e.ctrl = 4'b0111;
                else if (fn == 6'b100110) e.ctrl = 4'b1111;
                else begin
                    e.ctrl = 4'b0011;
                    e.ill  = 1'b1;
                end
            end
        endcase
        e.in1 = rs;
        if (!src)           e.in2 = rt;
        else if (op == 2'b11) e.in2 = {16'h0000, imm};
        else                e.in2 = {{16{imm[15]}}, imm};
        e.rd = rd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: a FIFO of at most two entries, ready whenever fewer than two are held
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mcnt = 0;
        end else begin
            m_acc = in_valid && (mq.size() < 2) && !flush;
            m_pop = (mq.size() > 0) && out_ready;
            m_e   = expect_entry(alu_op, funct, alu_src, rs_data, rt_data, imm16, rd_in);
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_acc) mq.push_back(m_e);
            end
            if (m_acc && m_e.ill && (mcnt < (1 << CW) - 1)) mcnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_ctrl", 32'(ctrl), 32'd0);
            chk("rst_in1", in1, 32'd0);
            chk("rst_in2", in2, 32'd0);
            chk("rst_cnt", 32'(illegal_cnt), 32'd0);
        end else begin
            chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
            chk("illegal_cnt", 32'(illegal_cnt), 32'(mcnt));
            if (mq.size() > 0) begin
                chk("ctrl", 32'(ctrl), 32'(mq[0].ctrl));
                chk("in1", in1, mq[0].in1);
                chk("in2", in2, mq[0].in2);
                chk("rd_out", 32'(rd_out), 32'(mq[0].rd));
                chk("illegal", 32'(illegal), 32'(mq[0].ill));
            end
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        alu_op   = 2'b00;
        funct    = 6'b000000;
        alu_src  = 1'b0;
        rs_data  = '0;
        rt_data  = '0;
        imm16    = '0;
        rd_in    = '0;
    endtask

    task automatic offer(input logic [1:0] op, input logic [5:0] fn, input logic src,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic [4:0] rd);
        in_valid = 1'b1;
        alu_op   = op;
        funct    = fn;
        alu_src  = src;
        rs_data  = rs;
        rt_data  = rt;
        imm16    = imm;
        rd_in    = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] fns [6];
    logic [3:0] exps[6];

    initial begin
        fns  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100110};
        exps = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1111};
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle();
        #1 rst_n = 1'b0;
        step();
        step();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_ctrl", 32'(ctrl), 32'd0);
        chk("reset_cnt", 32'(illegal_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // back-to-back R-type decode
        for (int i = 0; i < 6; i++) begin
            offer(2'b10, fns[i], 1'b0, 32'h100 + 32'(i), 32'h200 + 32'(i), 16'h0, 5'(i + 1));
            step();
            chk("b2b_ctrl", 32'(ctrl), 32'(exps[i]));
            chk("b2b_valid", 32'(out_valid), 32'd1);
        end
        idle();
        step();

        // immediate extension
        offer(2'b00, 6'b000000, 1'b1, 32'h1000, 32'h5, 16'hFFFC, 5'd7);
        step();
        chk("sext_in2", in2, 32'hFFFFFFFC);
        chk("sext_ctrl", 32'(ctrl), 32'h2);
        offer(2'b11, 6'b000000, 1'b1, 32'h1000, 32'h5, 16'hFFFC, 5'd8);
        step();
        chk("zext_in2", in2, 32'h0000FFFC);
        chk("zext_ctrl", 32'(ctrl), 32'h1);
        idle();
        step();

        // backpressure: A, B accepted, C held until release
        out_ready = 1'b0;
        offer(2'b00, 6'b0, 1'b0, 32'hA, 32'hA0, 16'h0, 5'd10);
        step();
        offer(2'b01, 6'b0, 1'b0, 32'hB, 32'hB0, 16'h0, 5'd11);
        step();
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        offer(2'b10, 6'b100000, 1'b0, 32'hC, 32'hC0, 16'h0, 5'd12);
        step();
        chk("bp_in_ready_held", 32'(in_ready), 32'd0);
        chk("bp_rd_a", 32'(rd_out), 32'd10);
        step();
        chk("bp_rd_a_stable", 32'(rd_out), 32'd10);
        out_ready = 1'b1;
        step();
        chk("bp_rd_b", 32'(rd_out), 32'd11);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
        step();
        chk("bp_rd_c", 32'(rd_out), 32'd12);
        idle();
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // flush with M and S full while offering D
        out_ready = 1'b0;
        offer(2'b00, 6'b0, 1'b0, 32'h20, 32'h0, 16'h0, 5'd20);
        step();
        offer(2'b00, 6'b0, 1'b0, 32'h21, 32'h0, 16'h0, 5'd21);
        step();
        offer(2'b00, 6'b0, 1'b0, 32'h22, 32'h0, 16'h0, 5'd22);
        flush = 1'b1;
        step();
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        idle();
        out_ready = 1'b1;
        step();
        step();
        chk("flush_no_d", 32'(out_valid), 32'd0);

        // illegal funct and counter saturation (CW=2)
        offer(2'b10, 6'b000000, 1'b0, 32'h30, 32'h31, 16'h0, 5'd3);
        step();
        chk("ill_ctrl", 32'(ctrl), 32'h3);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_cnt1", 32'(illegal_cnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            offer(2'b10, 6'b111111 - 6'(i), 1'b0, 32'h40, 32'h41, 16'h0, 5'd4);
            step();
        end
        chk("ill_cnt_sat", 32'(illegal_cnt), 32'd3);
        idle();
        step();

        // reset asserted mid-stall
        out_ready = 1'b0;
        offer(2'b00, 6'b0, 1'b0, 32'h50, 32'h51, 16'h0, 5'd5);
        step();
        offer(2'b01, 6'b0, 1'b0, 32'h52, 32'h53, 16'h0, 5'd6);
        step();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_ctrl", 32'(ctrl), 32'd0);
        chk("mrst_in1", in1, 32'd0);
        chk("mrst_in2", in2, 32'd0);
        chk("mrst_rd", 32'(rd_out), 32'd0);
        chk("mrst_illegal", 32'(illegal), 32'd0);
        chk("mrst_cnt", 32'(illegal_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
